// File: rtl/shift_register_universal.sv
// Universal DEPTH x WIDTH shift register: shift up/down, parallel load, saturating fill count.
// Latency: one enabled edge per stage; SI reaches SO_HI after DEPTH enabled shift-up edges.
// Backpressure: none; ce=0 freezes all state. Optional rotate input via SHIFT_REG_ROTATE_EN.
module shift_register_universal #(
  parameter int unsigned     WIDTH = 1,
  parameter int unsigned     DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ce,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           si,
  input  logic [WIDTH*DEPTH-1:0]     pi,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic                       rot,
`endif
  output logic [WIDTH-1:0]           so_hi,
  output logic [WIDTH-1:0]           so_lo,
  output logic [WIDTH*DEPTH-1:0]     po,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       full
);

  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam int unsigned TW = WIDTH * DEPTH;
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_UP    = 2'b01;
  localparam logic [1:0] MODE_DOWN  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Stage k lives at data_q[k*WIDTH +: WIDTH]; stage 0 is the low word.
  logic [TW-1:0] data_q, data_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          full_q;
  logic          rot_en;

`ifdef SHIFT_REG_ROTATE_EN
  assign rot_en = rot;
`else
  assign rot_en = 1'b0;
`endif

  // Next-state selection for data and fill count; rotation recirculates the end stage and keeps fill.
  always_comb begin
    data_d = data_q;
    fill_d = fill_q;
    case (mode)
      MODE_UP: begin
        if (rot_en) begin
          data_d = {data_q[TW-WIDTH-1:0], data_q[TW-1 -: WIDTH]};
        end else begin
          data_d = {data_q[TW-WIDTH-1:0], si};
          fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        end
      end
      MODE_DOWN: begin
        if (rot_en) begin
          data_d = {data_q[WIDTH-1:0], data_q[TW-1:WIDTH]};
        end else begin
          data_d = {si, data_q[TW-1:WIDTH]};
          fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        end
      end
      MODE_LOAD: begin
        data_d = pi;
        fill_d = FILL_MAX;
      end
      MODE_HOLD: begin
        data_d = data_q;
        fill_d = fill_q;
      end
      default: begin
        data_d = data_q;
        fill_d = fill_q;
      end
    endcase
  end

  // State registers: synchronous reset wins over enable; full tracks fill on the same edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_q <= {DEPTH{INIT}};
      fill_q <= '0;
      full_q <= 1'b0;
    end else if (ce) begin
      data_q <= data_d;
      fill_q <= fill_d;
      full_q <= (fill_d == FILL_MAX);
    end
  end

  assign po    = data_q;
  assign so_lo = data_q[WIDTH-1:0];
  assign so_hi = data_q[TW-1 -: WIDTH];
  assign fill  = fill_q;
  assign full  = full_q;

endmodule
